word_framer: RTL

//  Upstream stage of the begin/end block checker. Accepts raw ASCII bytes over a valid/ready

---
 rtl/word_framer.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/word_framer.sv
// ---------------------------------------------------------------------------
// word_framer
//   Front end of the begin/end block checker. Raw ASCII bytes arrive over a
//   valid/ready handshake; each whitespace-delimited word is buffered and then
//   replayed on out_char back-to-back, one character per clock, so the
//   downstream checker (which samples every clock with no enable) never sees a
//   word split by an idle gap. Between words out_char carries a space.
//
//   Words longer than MAX_WORD are truncated and followed by an extra '_' so
//   a truncated word can never alias a keyword.
//
// Parameters
//   MAX_WORD  word buffer depth in bytes (6..255)
//
// Ports
//   clk       in   rising-edge clock
//   reset     in   asynchronous, active-high; clears all state
//   in_valid  in   in_data holds a byte
//   in_data   in   [7:0] raw ASCII byte
//   in_ready  out  high while collecting; byte taken when in_valid&&in_ready
//   out_char  out  [7:0] registered character stream to the checker
//   out_busy  out  high while a word is being replayed (~in_ready)
//   word_cnt  out  [15:0] words flushed, wrapping (WORD_COUNT_EN only)
//
// Configuration
//   `define WORD_COUNT_EN to add the word_cnt port and its counter.
// ---------------------------------------------------------------------------
module word_framer #(
  parameter int MAX_WORD = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic [7:0] out_char,
  output logic       out_busy
`ifdef WORD_COUNT_EN
  ,output logic [15:0] word_cnt
`endif
);

  localparam int LW = $clog2(MAX_WORD + 1);  // len / idx width
  localparam int AW = $clog2(MAX_WORD);      // buffer address width

  localparam logic [7:0] SPACE = 8'h20;
  localparam logic [7:0] UNDER = 8'h5F;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    REPLAY  = 2'd1,
    TAIL    = 2'd2,
    SEP     = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [LW-1:0]   len_q, len_d;
  logic [LW-1:0]   idx_q, idx_d;
  logic            ovf_q, ovf_d;
  logic [7:0]      char_q, char_d;
  logic            wr_en;

  // Word storage; never reset, only read below len.
  logic [7:0]      wbuf_q [MAX_WORD];

  logic            is_delim;

  assign is_delim = (in_data == 8'h20) || (in_data == 8'h09) ||
                    (in_data == 8'h0A) || (in_data == 8'h0D);

  assign in_ready = (state_q == COLLECT);
  assign out_busy = ~in_ready;
  assign out_char = char_q;

  // -------------------------------------------------------------------------
  // Next-state / datapath
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    ovf_d   = ovf_q;
    char_d  = SPACE;
    wr_en   = 1'b0;

    unique case (state_q)
      COLLECT: begin
        if (in_valid) begin
          if (is_delim) begin
            // Empty word: delimiter runs collapse to nothing.
            if (len_q != '0) begin
              idx_d   = '0;
              state_d = REPLAY;
            end
          end else if (len_q < LW'(MAX_WORD)) begin
            wr_en = 1'b1;
            len_d = len_q + LW'(1);
          end else begin
            // Buffer full: drop the byte but remember the word was cut.
            ovf_d = 1'b1;
          end
        end
      end

      REPLAY: begin
        char_d = wbuf_q[idx_q[AW-1:0]];
        idx_d  = idx_q + LW'(1);
        if (idx_q == len_q - LW'(1))
          state_d = ovf_q ? TAIL : SEP;
      end

      TAIL: begin
        char_d  = UNDER;
        state_d = SEP;
      end

      SEP: begin
        char_d  = SPACE;
        len_d   = '0;
        ovf_d   = 1'b0;
        state_d = COLLECT;
      end

      default: state_d = COLLECT;
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= COLLECT;
      len_q   <= '0;
      idx_q   <= '0;
      ovf_q   <= 1'b0;
      char_q  <= SPACE;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      ovf_q   <= ovf_d;
      char_q  <= char_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      wbuf_q[len_q[AW-1:0]] <= in_data;
  end

`ifdef WORD_COUNT_EN
  // Counts SEP entries, i.e. words fully flushed to the checker.
  logic [15:0] word_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      word_cnt_q <= '0;
    else if (state_q == SEP)
      word_cnt_q <= word_cnt_q + 16'd1;
  end

  assign word_cnt = word_cnt_q;
`endif

endmodule
